// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read feeding a show-ahead instruction buffer.
// Optional redirect/flush support is compiled in with `define FETCH_REDIRECT_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
`ifdef FETCH_REDIRECT_EN
    ,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_e;

    state_e          state_q;
    logic [31:0]     pc_q;
    logic [31:0]     mem_addr_q;
    logic            mem_req_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [31:0]     data_mem [FIFO_DEPTH];
    logic [31:0]     pc_mem   [FIFO_DEPTH];

    logic            flush;
    logic [31:0]     flush_pc;
    logic            push;
    logic            pop;

`ifdef FETCH_REDIRECT_EN
    assign flush    = redirect;
    assign flush_pc = redirect_pc & ~32'h0000_0003;
`else
    assign flush    = 1'b0;
    assign flush_pc = '0;
`endif

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid & instr_ready;
    // A response arriving together with a redirect belongs to the old stream.
    assign push        = (state_q == WAIT) && mem_rvalid && !flush;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // NOTE: buffer storage has no reset; outputs are gated by instr_valid so stale contents never escape.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= mem_rdata;
            pc_mem[wr_ptr_q]   <= mem_addr_q;
        end
    end

    assign instr    = instr_valid ? data_mem[rd_ptr_q] : '0;
    assign instr_pc = instr_valid ? pc_mem[rd_ptr_q]   : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_q    <= WAIT;
                        pc_q       <= flush_pc;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= flush_pc;
                    end else if (count_q < DEPTH_C) begin
                        state_q    <= WAIT;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_q;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        pc_q <= flush_pc;
                        if (mem_rvalid) begin
                            mem_addr_q <= flush_pc;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (mem_rvalid) begin
                        pc_q <= pc_q + 32'd4;
                        if (count_d < DEPTH_C) begin
                            mem_addr_q <= pc_q + 32'd4;
                        end else begin
                            state_q   <= IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // The pending response is for a flushed address; reissue at the newest target.
                    if (flush) begin
                        pc_q <= flush_pc;
                    end
                    if (mem_rvalid) begin
                        state_q    <= WAIT;
                        mem_addr_q <= flush ? flush_pc : pc_q;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-configurable memory model and an in-order pop checker.
// A second instance with RESET_PC = 32'hFFFF_FFF8 exercises address wrap.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_req2;
    logic [31:0] mem_addr, mem_addr2;
    logic        mem_rvalid = 1'b0, mem_rvalid2 = 1'b0;
    logic [31:0] mem_rdata = '0, mem_rdata2 = '0;
    logic [31:0] instr, instr2, instr_pc, instr_pc2;
    logic        instr_valid, instr_valid2;
    logic        instr_ready = 1'b1;
    logic        instr_ready2 = 1'b1;
`ifdef FETCH_REDIRECT_EN
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = '0;
`endif

    int          vectors = 0;
    int          errors = 0;
    int          lat = 0;
    int          wait_cnt = 0;
    int          pop_cnt = 0;
    int          rvalid_cnt = 0;
    logic        late_rvalid = 1'b0;
    logic [31:0] exp_pc = '0;
    logic [31:0] pc2_q[$];
    logic [31:0] data2_q[$];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) u_dut (
        .clk         (clk),
`ifdef FETCH_REDIRECT_EN
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
`endif
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_wrap (
        .clk         (clk),
`ifdef FETCH_REDIRECT_EN
        .redirect    (redirect2),
        .redirect_pc (redirect_pc2),
`endif
        .reset       (reset),
        .mem_req     (mem_req2),
        .mem_addr    (mem_addr2),
        .mem_rvalid  (mem_rvalid2),
        .mem_rdata   (mem_rdata2),
        .instr       (instr2),
        .instr_pc    (instr_pc2),
        .instr_valid (instr_valid2),
        .instr_ready (instr_ready2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive memory for the current cycle, score any pop, then advance to 1 time unit past the next edge.
    task automatic tick(input int n);
        logic req_now;
        for (int i = 0; i < n; i++) begin
            req_now = mem_req;
            if (late_rvalid) begin
                mem_rvalid  = 1'b1;
                mem_rdata   = 32'hDEAD_BEEF;
                late_rvalid = 1'b0;
            end else if (mem_req && wait_cnt == lat) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_addr + 32'h1000;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
            mem_rvalid2 = mem_req2;
            mem_rdata2  = mem_addr2 + 32'h1000;
            if (instr_valid && instr_ready) begin
                check("order_pc", instr_pc, exp_pc);
                check("order_data", instr, exp_pc + 32'h1000);
                exp_pc = exp_pc + 32'd4;
                pop_cnt++;
            end
            if (instr_valid2) begin
                pc2_q.push_back(instr_pc2);
                data2_q.push_back(instr2);
            end
            if (mem_rvalid) rvalid_cnt++;
            @(posedge clk);
            #1;
            if (mem_rvalid || !req_now) wait_cnt = 0;
            else wait_cnt++;
        end
    endtask

    // Asserts reset mid-cycle, checks the asynchronous effect, and releases one unit after an edge.
    task automatic do_reset();
        reset       = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rvalid2 = 1'b0;
        wait_cnt    = 0;
        pop_cnt     = 0;
        rvalid_cnt  = 0;
        exp_pc      = '0;
        pc2_q.delete();
        data2_q.delete();
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_wrap_addr", mem_addr2, 32'hFFFF_FFF8);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Streaming with single-cycle memory and a core that is always ready.
        lat = 0;
        instr_ready = 1'b1;
        do_reset();
        check("idle_req", {31'd0, mem_req}, 32'd0);
        tick(1);
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h0);
        check("first_valid", {31'd0, instr_valid}, 32'd0);
        tick(1);
        check("lat_valid", {31'd0, instr_valid}, 32'd1);
        check("lat_pc", instr_pc, 32'h0);
        check("lat_instr", instr, 32'h0000_1000);
        tick(1);
        check("stream_pc1", instr_pc, 32'h4);
        tick(8);
        check("stream_pops", pop_cnt, 32'd9);
        check("stream_pc", instr_pc, 32'h24);
        check("stream_addr", mem_addr, 32'h28);

        check("wrap_pc0", pc2_q.size() > 0 ? pc2_q[0] : 32'hx, 32'hFFFF_FFF8);
        check("wrap_pc1", pc2_q.size() > 1 ? pc2_q[1] : 32'hx, 32'hFFFF_FFFC);
        check("wrap_pc2", pc2_q.size() > 2 ? pc2_q[2] : 32'hx, 32'h0000_0000);
        check("wrap_data0", data2_q.size() > 0 ? data2_q[0] : 32'hx, 32'h0000_0FF8);
        check("wrap_data2", data2_q.size() > 2 ? data2_q[2] : 32'hx, 32'h0000_1000);

        // Core stalled: buffer fills to depth, then fetching stops until it drains.
        instr_ready = 1'b0;
        do_reset();
        tick(5);
        check("full_req", {31'd0, mem_req}, 32'd0);
        check("full_rvalids", rvalid_cnt, 32'd4);
        check("full_hold_pc", instr_pc, 32'h0);
        tick(5);
        check("stall_req", {31'd0, mem_req}, 32'd0);
        check("stall_rvalids", rvalid_cnt, 32'd4);
        check("stall_valid", {31'd0, instr_valid}, 32'd1);
        check("stall_pc", instr_pc, 32'h0);
        check("stall_instr", instr, 32'h0000_1000);
        instr_ready = 1'b1;
        tick(10);
        check("resume_pops", pop_cnt, 32'd10);
        check("resume_pc", instr_pc, 32'h28);

        // Three wait cycles per access: address held, one instruction every four cycles.
        lat = 3;
        do_reset();
        tick(2);
        check("slow_req", {31'd0, mem_req}, 32'd1);
        check("slow_addr_c2", mem_addr, 32'h0);
        tick(1);
        check("slow_addr_c3", mem_addr, 32'h0);
        tick(1);
        check("slow_addr_c4", mem_addr, 32'h0);
        check("slow_valid_c4", {31'd0, instr_valid}, 32'd0);
        tick(1);
        check("slow_valid_c5", {31'd0, instr_valid}, 32'd1);
        check("slow_pc_c5", instr_pc, 32'h0);
        tick(1);
        check("slow_gap_c6", {31'd0, instr_valid}, 32'd0);
        check("slow_addr_c6", mem_addr, 32'h4);
        tick(15);
        check("slow_pops", pop_cnt, 32'd4);
        check("slow_pc_c21", instr_pc, 32'h10);

        // Reset while a request is pending; a late response after release is ignored.
        do_reset();
        tick(2);
        check("mid_req", {31'd0, mem_req}, 32'd1);
        do_reset();
        late_rvalid = 1'b1;
        tick(1);
        check("late_req", {31'd0, mem_req}, 32'd1);
        check("late_addr", mem_addr, 32'h0);
        check("late_valid", {31'd0, instr_valid}, 32'd0);
        tick(4);
        check("restart_valid", {31'd0, instr_valid}, 32'd1);
        check("restart_pc", instr_pc, 32'h0);
        check("restart_instr", instr, 32'h0000_1000);

`ifdef FETCH_REDIRECT_EN
        // Redirect while a request is pending with three buffered entries.
        lat = 1;
        instr_ready = 1'b0;
        do_reset();
        tick(7);
        check("pre_redir_addr", mem_addr, 32'hC);
        check("pre_redir_valid", {31'd0, instr_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        tick(1);
        redirect = 1'b0;
        check("drain_valid", {31'd0, instr_valid}, 32'd0);
        check("drain_req", {31'd0, mem_req}, 32'd1);
        check("drain_addr", mem_addr, 32'hC);
        tick(1);
        check("redir_addr", mem_addr, 32'h200);
        check("redir_empty", {31'd0, instr_valid}, 32'd0);
        tick(2);
        check("redir_valid", {31'd0, instr_valid}, 32'd1);
        check("redir_pc", instr_pc, 32'h200);
        check("redir_instr", instr, 32'h0000_1200);
        exp_pc = 32'h200;
        instr_ready = 1'b1;
        tick(6);
        check("redir_pops", {31'd0, pop_cnt > 0}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  RESET_PC  32'h0000_0000  fetch address loaded on reset; must be word aligned.
  FIFO_DEPTH  4  instruction buffer entries; power of two, 2..16.
REQ-002 Ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on its rising edge.
  reset  in  1  asynchronous, active-low reset.
  mem_req  out  1  read request to instruction memory, held until completed.
  mem_addr  out  32  word-aligned request address, stable while mem_req=1.
  mem_rvalid  in  1  completes the current request; mem_rdata valid this cycle.
  mem_rdata  in  32  fetched instruction word.
  instr  out  32  instruction at buffer head, driven to the core's INSTR input.
  instr_pc  out  32  address of instr.
  instr_valid  out  1  buffer non-empty; instr/instr_pc valid.
  instr_ready  in  1  core accepts head this cycle when instr_valid=1.
  redirect  in  1  flush and restart at redirect_pc (FETCH_REDIRECT_EN only).
  redirect_pc  in  32  new fetch address (FETCH_REDIRECT_EN only).

Function
REQ-003 Block SHALL keep at most one outstanding memory request.
REQ-004 FSM states SHALL be IDLE (no request), WAIT (mem_req=1, awaiting mem_rvalid), DRAIN (mem_req=1, response to be discarded).
REQ-005 IDLE->WAIT SHALL occur when buffer count < FIFO_DEPTH; mem_addr = PC in that cycle and onward.
REQ-006 In WAIT with mem_rvalid=1, block SHALL push {mem_rdata, mem_addr}, set PC = PC+4 (mod 2^32, wraps to 0), then stay WAIT if count after push/pop < FIFO_DEPTH, else go IDLE.
REQ-007 mem_req and mem_addr SHALL NOT change while a request is pending (WAIT/DRAIN without mem_rvalid).
REQ-008 mem_rvalid in IDLE SHALL be ignored.
REQ-009 Buffer SHALL be show-ahead FIFO: instr/instr_pc reflect head combinationally; pop when instr_valid & instr_ready.
REQ-010 Simultaneous push and pop SHALL leave count unchanged; order preserved; pop on empty and push on full SHALL never occur.
REQ-011 Latency: word returned on mem_rvalid in cycle N SHALL appear with instr_valid=1 in cycle N+1 if buffer was empty.
REQ-012 Sustained throughput SHALL be one instruction per cycle when memory returns mem_rvalid every cycle and instr_ready=1.
REQ-013 instr/instr_pc SHALL hold their values while instr_valid=1 and instr_ready=0.

Reset
REQ-014 reset=0 SHALL asynchronously force: state IDLE, PC=RESET_PC, count 0, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-015 Reset mid-request SHALL abandon the request; a late mem_rvalid after release SHALL be ignored (state IDLE).
REQ-016 First mem_req SHALL assert in the first cycle after reset release.

Configuration
REQ-017 Macro FETCH_REDIRECT_EN SHALL compile in redirect and redirect_pc; undefined, those ports are absent and PC advances strictly sequentially.
REQ-018 With macro, redirect=1 SHALL, next cycle: empty buffer (instr_valid=0), PC = {redirect_pc[31:2],2'b00}; a same-cycle pop is discarded.
REQ-019 Redirect in WAIT without mem_rvalid SHALL go DRAIN; in DRAIN, on mem_rvalid discard data and go WAIT at new PC.
REQ-020 Redirect in WAIT with mem_rvalid same cycle SHALL discard that data and go WAIT at new PC next cycle.
REQ-021 Redirect in DRAIN SHALL update PC only; redirect in IDLE SHALL go WAIT at new PC.

Verification
REQ-022 Reset release, memory returns word at addr+0x1000 in 1 cycle, instr_ready=1 -> instr_pc 0,4,8,... one per cycle, instr matches memory.
REQ-023 instr_ready=0 for 10 cycles, FIFO_DEPTH=4 -> exactly 4 pushes, mem_req=0 afterwards, instr holds addr 0 word; ready=1 -> resumes in order.
REQ-024 Memory latency 3 cycles -> mem_addr stable over pending cycles, one instruction per 4 cycles, no duplicates or gaps.
REQ-025 RESET_PC=32'hFFFF_FFF8 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-026 FETCH_REDIRECT_EN, redirect to 32'h0000_0203 while WAIT pending -> DRAIN, stale word dropped, next instr_pc=0x200, buffer previously held 3 entries all flushed.
REQ-027 Assert reset=0 mid-WAIT, memory returns mem_rvalid after release -> response ignored, fetch restarts at RESET_PC.
